// File: rtl/interrupt_service_sequencer.sv
// 8259 interrupt-service sequencer (8086 mode): priority resolution,
// in-service register, two-pulse INTA acknowledge and OCW2 EOI/rotate.
module interrupt_service_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic [7:0] IRR,
    input  logic [7:0] OCW1,
    input  logic [4:0] ICW2,
    input  logic       ICW4_AEOI,
    input  logic       INTA,
    input  logic       eoi_valid,
    input  logic [2:0] eoi_cmd,
    input  logic [2:0] eoi_level,
    output logic       INT,
    output logic [7:0] ISR,
    output logic [7:0] clear_IRR,
    output logic [7:0] vector_out,
    output logic       vector_oe,
    output logic [2:0] lowest_priority
);

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t     state_q, state_d;
    logic       inta_q;
    logic       int_q, int_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clr_q, clr_d;
    logic [7:0] vec_q, vec_d;
    logic       oe_q, oe_d;
    logic [2:0] lp_q, lp_d;
    logic       ar_q, ar_d;
    logic [2:0] idx_q, idx_d;
    logic       spur_q, spur_d;

    logic       fall, rise;
    logic [7:0] pending;
    logic [2:0] cand, hi_isr;
    logic [2:0] cand_rank, hi_rank;
    logic       req_ok;
    logic [7:0] eoi_clr, aeoi_clr, ack_set;
    logic       eoi_lp_v, aeoi_lp_v;
    logic [2:0] eoi_lp;

    // First set bit scanning upward from the highest-priority position.
    function automatic logic [2:0] first_pri(input logic [7:0] v,
                                             input logic [2:0] lp);
        logic [2:0] k;
        logic       hit;
        first_pri = 3'd0;
        hit       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k = lp + 3'(i + 1);
            if (!hit && v[k]) begin
                first_pri = k;
                hit       = 1'b1;
            end
        end
    endfunction

    assign fall      = inta_q & ~INTA;
    assign rise      = ~inta_q & INTA;
    assign pending   = IRR & ~OCW1;
    assign cand      = first_pri(pending, lp_q);
    assign hi_isr    = first_pri(isr_q, lp_q);
    assign cand_rank = cand - lp_q - 3'd1;
    assign hi_rank   = hi_isr - lp_q - 3'd1;
    assign req_ok    = (pending != 8'd0) &&
                       ((isr_q == 8'd0) || (cand_rank < hi_rank));

    // INTA edge register keeps tracking the pin even while uninitialised.
    always_ff @(posedge clk) begin
        if (reset) inta_q <= 1'b1;
        else       inta_q <= INTA;
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk) begin
        if (reset || !init_done) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            isr_q   <= 8'd0;
            clr_q   <= 8'd0;
            vec_q   <= 8'd0;
            oe_q    <= 1'b0;
            lp_q    <= 3'd7;
            ar_q    <= 1'b0;
            idx_q   <= 3'd0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            isr_q   <= isr_d;
            clr_q   <= clr_d;
            vec_q   <= vec_d;
            oe_q    <= oe_d;
            lp_q    <= lp_d;
            ar_q    <= ar_d;
            idx_q   <= idx_d;
            spur_q  <= spur_d;
        end
    end

    // Next-state: EOI decode, acknowledge FSM, ISR and pointer merge.
    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        clr_d     = 8'd0;
        vec_d     = vec_q;
        oe_d      = oe_q;
        ar_d      = ar_q;
        idx_d     = idx_q;
        spur_d    = spur_q;
        eoi_clr   = 8'd0;
        aeoi_clr  = 8'd0;
        ack_set   = 8'd0;
        eoi_lp_v  = 1'b0;
        eoi_lp    = lp_q;
        aeoi_lp_v = 1'b0;

        if (eoi_valid) begin
            case (eoi_cmd)
                3'b001: begin
                    if (isr_q != 8'd0) eoi_clr[hi_isr] = 1'b1;
                end
                3'b011: eoi_clr[eoi_level] = 1'b1;
                3'b101: begin
                    if (isr_q != 8'd0) begin
                        eoi_clr[hi_isr] = 1'b1;
                        eoi_lp_v        = 1'b1;
                        eoi_lp          = hi_isr;
                    end
                end
                3'b111: begin
                    eoi_clr[eoi_level] = 1'b1;
                    eoi_lp_v           = 1'b1;
                    eoi_lp             = eoi_level;
                end
                3'b110: begin
                    eoi_lp_v = 1'b1;
                    eoi_lp   = eoi_level;
                end
                3'b100: ar_d = 1'b1;
                3'b000: ar_d = 1'b0;
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                int_d = req_ok;
                if (fall) begin
                    idx_d  = req_ok ? cand : 3'd7;
                    spur_d = ~req_ok;
                    if (req_ok) ack_set[cand] = 1'b1;
                    clr_d   = ack_set;
                    vec_d   = {ICW2, idx_d};
                    int_d   = 1'b0;
                    state_d = ACK1;
                end
            end
            ACK1: begin
                if (rise) state_d = GAP;
            end
            GAP: begin
                if (fall) begin
                    oe_d    = 1'b1;
                    state_d = ACK2;
                end
            end
            ACK2: begin
                if (rise) begin
                    oe_d = 1'b0;
                    if (ICW4_AEOI && !spur_q) begin
                        aeoi_clr[idx_q] = 1'b1;
                        aeoi_lp_v       = ar_q;
                    end
                    state_d = IDLE;
                end
            end
        endcase

        isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_set;
        if (eoi_lp_v)       lp_d = eoi_lp;
        else if (aeoi_lp_v) lp_d = idx_q;
        else                lp_d = lp_q;
    end

    assign INT             = int_q;
    assign ISR             = isr_q;
    assign clear_IRR       = clr_q;
    assign vector_out      = vec_q;
    assign vector_oe       = oe_q;
    assign lowest_priority = lp_q;

endmodule
